eth_rx_frontend: RTL and testbench
==================================

# eth_rx_frontend

Receive-side front end placed directly upstream of the NE2000 emulation core's rx byte interface. It captures one frame at a time from the io controller's SPI byte stream into a local frame buffer and checks the destination MAC against the station address, broadcast and multicast. Accepted frames are length-checked, optionally padded to the Ethernet minimum, and replayed to the core as a clean begin/strobe/byte sequence with guaranteed spacing. Rejected and oversize frames are dropped and counted, so the core only sees frames it should store.

## Interface
- `STROBE_GAP`, 3: idle cycles between consecutive `rx_strobe` pulses; minimum 1.
- `HOLDOFF`, 8: cycles after `rx_begin` falls before the next frame may start; covers the core's header write.
- `MAXLEN`, 1514: largest accepted frame in bytes.
- `clk`  in  1  single system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in_begin`  in  1  level signal, high for the duration of an io controller frame.
- `in_strobe`  in  1  one-cycle pulse per byte, `in_byte` valid in the same cycle.
- `in_byte`  in  8  frame byte.
- `mac`  in  48  station address; byte 0 is `mac[47:40]`.
- `promisc`  in  1  accept every frame, regardless of destination.
- `rx_begin`  out  1  high from frame start until after the last strobe.
- `rx_strobe`  out  1  one-cycle pulse per byte.
- `rx_byte`  out  8  byte to the core, valid while `rx_strobe` is high.
- `busy`  out  1  high whenever the state is not IDLE.
- `drop_cnt`  out  16  count of dropped frames; saturates at 0xFFFF.

## Operation
- Local buffer: 1536×8. Write counter `wcnt[10:0]`, read counter `rcnt[10:0]`.
- **IDLE**
  - A rising edge of `in_begin` (registered compare) sets `wcnt`=0 and moves to CAPTURE.
  - Strobes in IDLE are ignored.
- **CAPTURE**
  - Each `in_strobe` writes `in_byte` to buf[`wcnt`] and increments `wcnt`.
  - Bytes 0–5 are also compared on the fly, giving flags `ucast` (equal to `mac`), `bcast` (all 0xFF) and `mcast` (byte 0 bit 0 set).
  - Once `wcnt` reaches `MAXLEN`, further writes are suppressed and an oversize flag is set.
  - The falling edge of `in_begin` moves to DECIDE.
- **DECIDE** (1 cycle)
  - Accept when: not oversize, `wcnt` ≥ 6, and (`promisc` | `ucast` | `bcast` | `mcast`).
  - Accept: `len` = `wcnt`, then go to START.
  - Otherwise: `drop_cnt`++ and go to IDLE.
- **START**: `rx_begin`=1, wait 2 cycles, `rcnt`=0, go to SEND.
- **SEND**
  - Drive `rx_byte` and pulse `rx_strobe` for one cycle.
  - Byte value: buf[`rcnt`] when `rcnt` < `wcnt`, else 0x00 (padding).
  - Increment `rcnt`, then go to GAP.
- **GAP**
  - Wait `STROBE_GAP` cycles.
  - If `rcnt` == `len`, go to END; otherwise go back to SEND.
- **END**: keep `rx_begin` high for 1 cycle, then drop it; go to HOLD.
- **HOLD**: wait `HOLDOFF` cycles, then go to IDLE.
- **Overlap**: an `in_begin` rising edge in any state other than IDLE (and not during CAPTURE) drops that incoming frame.
  - `drop_cnt` increments once, at its falling edge.
  - The current replay is not disturbed.
- **Reset**
  - All outputs go to 0 and the state goes to IDLE; `drop_cnt` is cleared.
  - Buffer contents are not cleared.
  - Reset during replay truncates the frame with `rx_begin` low immediately.

## Timing
- The rising edge of `in_begin` is seen 1 cycle later; each capture write takes effect in the cycle after `in_strobe`.
- The first `rx_strobe` occurs exactly 3 cycles after `rx_begin` rises.
- Strobe period is `STROBE_GAP`+2 cycles (SEND, GAP cycles, then the compare cycle): 5 cycles at the default.
- `rx_byte` changes only in the cycle of `rx_strobe` and is held afterwards.
- An accepted frame starts (`rx_begin` rise) 3 cycles after the falling edge of `in_begin`.
- `drop_cnt` updates 2 cycles after the falling edge of `in_begin`.

## Configuration
- `ETH_RX_PAD_EN` defined:
  - `len` = max(`wcnt`, 60); frames shorter than 60 bytes are zero-padded to 60 on replay.
- `ETH_RX_PAD_EN` undefined:
  - `len` = `wcnt`.
  - Frames shorter than 60 bytes are dropped in DECIDE and counted in `drop_cnt`.

## Test plan
- 64-byte frame with destination equal to `mac` 02:00:11:22:33:44 -> 64 `rx_strobe` pulses 5 cycles apart, bytes identical to the input, `drop_cnt`=0.
- Destination 02:00:11:22:33:45, `promisc`=0 -> no `rx_begin`, `drop_cnt`=1; repeat with `promisc`=1 -> 64 strobes.
- Broadcast 42-byte frame:
  - With `ETH_RX_PAD_EN`: 60 strobes, bytes 42–59 = 0x00.
  - Without it: no replay, `drop_cnt`=1.
- 1600-byte frame -> dropped, `drop_cnt`=1, `busy` low 1 cycle after DECIDE.
- Second `in_begin` while the first frame is replaying -> first frame completes intact, second frame dropped, `drop_cnt`=1, `busy` falls `HOLDOFF` cycles after `rx_begin` falls.
- Assert `reset` mid-SEND -> `rx_begin`/`rx_strobe`=0 immediately, `drop_cnt`=0; the next valid frame replays correctly.

Source files
------------

// File: rtl/eth_rx_frontend_if.sv
// Byte-stream frame bus: level 'frame' brackets a frame, one-cycle 'strobe' qualifies 'data'.
interface eth_rx_frontend_if;
  logic       frame;
  logic       strobe;
  logic [7:0] data;

  modport master (output frame, strobe, data);
  modport slave  (input  frame, strobe, data);
endinterface

// File: rtl/eth_rx_frontend.sv
// Ethernet rx front end: buffers one frame, filters on destination MAC, replays accepted frames to the core.
// Optional feature macro ETH_RX_PAD_EN: zero-pad short frames to 60 bytes instead of dropping them.
module eth_rx_frontend #(
  parameter int STROBE_GAP = 3,
  parameter int HOLDOFF    = 8,
  parameter int MAXLEN     = 1514
) (
  input  logic              clk,
  input  logic              reset,
  eth_rx_frontend_if.slave  src,
  eth_rx_frontend_if.master core,
  input  logic [47:0]       mac,
  input  logic              promisc,
  output logic              busy,
  output logic [15:0]       drop_cnt
);

  localparam int          DEPTH     = 1536;
  localparam logic [10:0] MIN_LEN   = 11'd60;
  localparam logic [10:0] MAX_LEN   = 11'(MAXLEN);
  localparam logic [7:0]  GAP_LAST  = 8'(STROBE_GAP);
  localparam logic [7:0]  HOLD_LAST = 8'(HOLDOFF - 1);

  typedef enum logic [2:0] {IDLE, CAPTURE, DECIDE, START, SEND, GAP, END, HOLD} state_t;

  state_t      state_reg, state_next;
  logic        begin_q_reg;
  logic [10:0] wcnt_reg, rcnt_reg, len_reg, len_calc;
  logic [7:0]  cnt_reg;
  logic        ucast_reg, bcast_reg, mcast_reg, oversize_reg, ovl_reg, ovl_fall_reg;
  logic [7:0]  rd_data_reg;
  logic        rx_begin_reg, rx_begin_next;
  logic        rx_strobe_reg, rx_strobe_next;
  logic [7:0]  rx_byte_reg, rx_byte_next;
  logic        busy_reg, busy_next;
  logic [15:0] drop_cnt_reg;
  logic        rise, fall, wr_en, accept, long_enough, drop_inc;
  logic [7:0]  mac_bytes [8];
  logic [7:0]  frame_mem [DEPTH];

  // Station address bytes in wire order; slots 6 and 7 are never compared.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_mac
      if (gi < 6) begin : g_byte
        assign mac_bytes[gi] = mac[47 - 8*gi -: 8];
      end else begin : g_pad
        assign mac_bytes[gi] = 8'h00;
      end
    end
  endgenerate

  assign rise  = src.frame & ~begin_q_reg;
  assign fall  = ~src.frame & begin_q_reg;
  assign wr_en = (state_reg == CAPTURE) && src.strobe && (wcnt_reg != MAX_LEN);

`ifdef ETH_RX_PAD_EN
  assign len_calc    = (wcnt_reg < MIN_LEN) ? MIN_LEN : wcnt_reg;
  assign long_enough = 1'b1;
`else
  assign len_calc    = wcnt_reg;
  assign long_enough = (wcnt_reg >= MIN_LEN);
`endif

  assign accept   = !oversize_reg && (wcnt_reg >= 11'd6) && long_enough &&
                    (promisc | ucast_reg | bcast_reg | mcast_reg);
  assign drop_inc = ((state_reg == DECIDE) && !accept) || ovl_fall_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (rise) state_next = CAPTURE;
      CAPTURE: if (fall) state_next = DECIDE;
      DECIDE:  state_next = accept ? START : IDLE;
      START:   if (cnt_reg == 8'd2) state_next = SEND;
      SEND:    state_next = GAP;
      GAP:     if (cnt_reg == GAP_LAST) state_next = (rcnt_reg == len_reg) ? END : SEND;
      END:     state_next = HOLD;
      HOLD:    if (cnt_reg == HOLD_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rx_begin_next  = (state_reg == START) || (state_reg == SEND) ||
                     (state_reg == GAP)   || (state_reg == END);
    rx_strobe_next = (state_reg == SEND);
    busy_next      = (state_reg != IDLE);
    rx_byte_next   = rx_byte_reg;
    if (state_reg == SEND) rx_byte_next = (rcnt_reg < wcnt_reg) ? rd_data_reg : 8'h00;
  end

  // Outputs lag the state by one cycle so the replayed byte comes from a registered RAM read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_begin_reg  <= 1'b0;
      rx_strobe_reg <= 1'b0;
      rx_byte_reg   <= 8'h00;
      busy_reg      <= 1'b0;
    end else begin
      rx_begin_reg  <= rx_begin_next;
      rx_strobe_reg <= rx_strobe_next;
      rx_byte_reg   <= rx_byte_next;
      busy_reg      <= busy_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      begin_q_reg  <= 1'b0;
      cnt_reg      <= 8'd0;
      wcnt_reg     <= 11'd0;
      rcnt_reg     <= 11'd0;
      len_reg      <= 11'd0;
      ucast_reg    <= 1'b0;
      bcast_reg    <= 1'b0;
      mcast_reg    <= 1'b0;
      oversize_reg <= 1'b0;
      ovl_reg      <= 1'b0;
      ovl_fall_reg <= 1'b0;
      drop_cnt_reg <= 16'd0;
    end else begin
      begin_q_reg  <= src.frame;
      cnt_reg      <= (state_next != state_reg) ? 8'd0 : cnt_reg + 8'd1;
      ovl_fall_reg <= fall && ovl_reg;
      case (state_reg)
        IDLE: if (rise) begin
          wcnt_reg     <= 11'd0;
          ucast_reg    <= 1'b1;
          bcast_reg    <= 1'b1;
          mcast_reg    <= 1'b0;
          oversize_reg <= 1'b0;
        end
        CAPTURE: if (src.strobe) begin
          if (wcnt_reg == MAX_LEN) begin
            oversize_reg <= 1'b1;
          end else begin
            wcnt_reg <= wcnt_reg + 11'd1;
            if (wcnt_reg < 11'd6) begin
              if (src.data != mac_bytes[wcnt_reg[2:0]]) ucast_reg <= 1'b0;
              if (src.data != 8'hFF) bcast_reg <= 1'b0;
              if (wcnt_reg == 11'd0) mcast_reg <= src.data[0];
            end
          end
        end
        DECIDE: if (accept) begin
          len_reg  <= len_calc;
          rcnt_reg <= 11'd0;
        end
        SEND: rcnt_reg <= rcnt_reg + 11'd1;
        default: ;
      endcase
      // A frame that starts while we are busy is ignored and counted when it ends.
      if (rise && (state_reg != IDLE) && (state_reg != CAPTURE)) ovl_reg <= 1'b1;
      else if (fall)                                               ovl_reg <= 1'b0;
      if (drop_inc && (drop_cnt_reg != 16'hFFFF)) drop_cnt_reg <= drop_cnt_reg + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) frame_mem[wcnt_reg] <= src.data;
    rd_data_reg <= frame_mem[rcnt_reg];
  end

  assign core.frame  = rx_begin_reg;
  assign core.strobe = rx_strobe_reg;
  assign core.data   = rx_byte_reg;
  assign busy        = busy_reg;
  assign drop_cnt    = drop_cnt_reg;

endmodule

// File: tb/tb_eth_rx_frontend.sv
// Directed bench for eth_rx_frontend: filtering, replay timing, drops, overlap and reset.
module tb_eth_rx_frontend;
  localparam logic [47:0] MAC  = 48'h02_00_11_22_33_44;
  localparam logic [47:0] MAC1 = 48'h02_00_11_22_33_45;
  localparam logic [47:0] BC   = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] MC   = 48'h01_00_5E_00_00_01;

  logic        clk = 1'b0;
  logic        reset;
  logic [47:0] mac;
  logic        promisc;
  logic        busy;
  logic [15:0] drop_cnt;

  eth_rx_frontend_if src ();
  eth_rx_frontend_if core ();

  eth_rx_frontend dut (
    .clk(clk), .reset(reset), .src(src), .core(core),
    .mac(mac), .promisc(promisc), .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Replay monitor: records every strobed byte and the edges of rx_begin and busy.
  logic [7:0] got_q [$];
  int         stb_cyc [$];
  int         rises = 0;
  int         rise_cyc = -100;
  int         begin_fall_cyc = -100;
  int         busy_fall_cyc = -100;
  logic       prev_begin = 1'b0;
  logic       prev_busy = 1'b0;

  always @(negedge clk) begin
    if (core.strobe === 1'b1) begin
      got_q.push_back(core.data);
      stb_cyc.push_back(cyc);
    end
    if (core.frame === 1'b1 && !prev_begin) begin
      rises    <= rises + 1;
      rise_cyc <= cyc;
    end
    if (core.frame !== 1'b1 && prev_begin) begin_fall_cyc <= cyc;
    if (busy !== 1'b1 && prev_busy) busy_fall_cyc <= cyc;
    prev_begin <= (core.frame === 1'b1);
    prev_busy  <= (busy === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int i, input int n, input logic [47:0] dst,
                                          input logic [7:0] seed);
    if (i < 6)      return dst[47 - 8*i -: 8];
    else if (i < n) return seed + 8'(i);
    else            return 8'h00;
  endfunction

  // Returns at the negedge where in_begin was driven low; fall_at is the cycle count there.
  task automatic send_frame(input int n, input logic [47:0] dst, input logic [7:0] seed,
                            output int fall_at);
    @(negedge clk);
    src.frame = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      src.strobe = 1'b1;
      src.data   = exp_byte(i, n, dst, seed);
      @(negedge clk);
      src.strobe = 1'b0;
      repeat (2) @(negedge clk);
    end
    src.frame = 1'b0;
    fall_at   = cyc;
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 3000 && busy !== 1'b0; k++) @(negedge clk);
    chk(tag, 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  task automatic check_replay(input string tag, input int base, input int rb, input int n_exp,
                              input int n_frame, input logic [47:0] dst, input logic [7:0] seed,
                              input int f);
    int got, bad_byte, bad_gap, first;
    got = got_q.size() - base;
    bad_byte = 0;
    bad_gap = 0;
    chk({tag, "_count"}, 32'(got), 32'(n_exp));
    for (int i = 0; i < got && i < n_exp; i++)
      if (got_q[base + i] !== exp_byte(i, n_frame, dst, seed)) bad_byte++;
    chk({tag, "_bytes_bad"}, 32'(bad_byte), 32'd0);
    for (int i = base + 1; i < got_q.size(); i++)
      if (stb_cyc[i] - stb_cyc[i - 1] != 5) bad_gap++;
    chk({tag, "_gap_bad"}, 32'(bad_gap), 32'd0);
    first = (got > 0) ? stb_cyc[base] - rise_cyc : -1;
    chk({tag, "_first_strobe"}, 32'(first), 32'd3);
    chk({tag, "_begin_lat"}, 32'(rise_cyc - f), 32'd3);
    chk({tag, "_rises"}, 32'(rises - rb), 32'd1);
    chk({tag, "_holdoff"}, 32'(busy_fall_cyc - begin_fall_cyc), 32'd8);
  endtask

  int exp_drop = 0;

  task automatic check_drop(input string tag, input int f, input int base, input int rb);
    chk({tag, "_drop_early"}, 32'(drop_cnt), 32'(exp_drop));
    @(negedge clk);
    exp_drop++;
    chk({tag, "_drop"}, 32'(drop_cnt), 32'(exp_drop));
    chk({tag, "_busy_decide"}, 32'(busy), 32'd1);
    @(negedge clk);
    chk({tag, "_busy_low"}, 32'(busy), 32'd0);
    wait_idle({tag, "_idle"});
    chk({tag, "_no_begin"}, 32'(rises - rb), 32'd0);
    chk({tag, "_no_strobe"}, 32'(got_q.size() - base), 32'd0);
  endtask

  int f, fb, base, rb;

  initial begin
    reset = 1'b1;
    src.frame = 1'b0;
    src.strobe = 1'b0;
    src.data = 8'h00;
    mac = MAC;
    promisc = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_begin", 32'(core.frame), 32'd0);
    chk("rst_strobe", 32'(core.strobe), 32'd0);
    chk("rst_byte", 32'(core.data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Unicast to our address
    base = got_q.size(); rb = rises;
    send_frame(64, MAC, 8'h10, f);
    wait_idle("ucast_idle");
    check_replay("ucast", base, rb, 64, 64, MAC, 8'h10, f);
    chk("ucast_drop", 32'(drop_cnt), 32'(exp_drop));

    // Unicast to another station, not promiscuous
    base = got_q.size(); rb = rises;
    send_frame(64, MAC1, 8'h20, f);
    @(negedge clk);
    check_drop("other", f, base, rb);

    // Same frame in promiscuous mode
    promisc = 1'b1;
    base = got_q.size(); rb = rises;
    send_frame(64, MAC1, 8'h20, f);
    wait_idle("promisc_idle");
    check_replay("promisc", base, rb, 64, 64, MAC1, 8'h20, f);
    promisc = 1'b0;

    // Short broadcast frame
    base = got_q.size(); rb = rises;
    send_frame(42, BC, 8'h30, f);
`ifdef ETH_RX_PAD_EN
    wait_idle("bcast_idle");
    check_replay("bcast_pad", base, rb, 60, 42, BC, 8'h30, f);
`else
    @(negedge clk);
    check_drop("bcast_short", f, base, rb);
`endif

    // Multicast frame at exactly the minimum length
    base = got_q.size(); rb = rises;
    send_frame(60, MC, 8'h38, f);
    wait_idle("mcast_idle");
    check_replay("mcast", base, rb, 60, 60, MC, 8'h38, f);

    // Oversize frame
    base = got_q.size(); rb = rises;
    send_frame(1600, MAC, 8'h48, f);
    @(negedge clk);
    check_drop("oversize", f, base, rb);

    // Second frame arrives while the first is replaying
    base = got_q.size(); rb = rises;
    send_frame(64, MAC, 8'h50, f);
    for (int k = 0; k < 200 && got_q.size() == base; k++) @(negedge clk);
    send_frame(20, MAC, 8'h90, fb);
    @(negedge clk);
    chk("ovl_drop_early", 32'(drop_cnt), 32'(exp_drop));
    @(negedge clk);
    exp_drop++;
    chk("ovl_drop", 32'(drop_cnt), 32'(exp_drop));
    chk("ovl_busy", 32'(busy), 32'd1);
    wait_idle("ovl_idle");
    check_replay("ovl_first", base, rb, 64, 64, MAC, 8'h50, f);
    chk("ovl_drop_once", 32'(drop_cnt), 32'(exp_drop));

    // Reset in the middle of a replay
    base = got_q.size();
    send_frame(64, MAC, 8'h60, f);
    for (int k = 0; k < 400 && got_q.size() < base + 10; k++) @(negedge clk);
    for (int k = 0; k < 10 && core.strobe !== 1'b1; k++) @(negedge clk);
    chk("mid_replay_strobe", 32'(core.strobe), 32'd1);
    #1 reset = 1'b1;
    #1;
    exp_drop = 0;
    chk("rst_mid_begin", 32'(core.frame), 32'd0);
    chk("rst_mid_strobe", 32'(core.strobe), 32'd0);
    chk("rst_mid_byte", 32'(core.data), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_drop", 32'(drop_cnt), 32'(exp_drop));
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Next valid frame after reset
    base = got_q.size(); rb = rises;
    send_frame(64, MAC, 8'h70, f);
    wait_idle("after_rst_idle");
    check_replay("after_rst", base, rb, 64, 64, MAC, 8'h70, f);
    chk("after_rst_drop", 32'(drop_cnt), 32'(exp_drop));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
